// File: rtl/imm_ext_pipe.sv
// Immediate extender between decode and execute: five extension modes, registered
// behind a valid/ready handshake with a two-entry skid buffer (main + skid register).
module imm_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ext_op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [DATA_W-1:0] pc4,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              err_out,
  output logic [7:0]        illegal_cnt
);

  localparam logic [2:0] OP_ZERO   = 3'b000;
  localparam logic [2:0] OP_SIGNED = 3'b001;
  localparam logic [2:0] OP_HIGH   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_JUMP   = 3'b100;

  // Low bits of a jump target that come from {jidx, 2'b00}; the rest come from pc4.
  localparam logic [DATA_W-1:0] JLO_MASK = {DATA_W{1'b1}} >> (DATA_W - JIDX_W - 2);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } beat_t;

  beat_t             new_beat;
  beat_t             m_q, m_d, s_q, s_d;
  logic              m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] sext;
  logic              acc;

  assign in_ready    = !s_vld_q;
  assign acc         = in_valid && in_ready;
  assign out_valid   = m_vld_q;
  assign imm_out     = m_q.data;
  assign tag_out     = m_q.tag;
  assign err_out     = m_q.err;
  assign illegal_cnt = cnt_q;

  always_comb begin
    sext         = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    new_beat     = '0;
    new_beat.tag = tag_in;
    case (ext_op)
      OP_ZERO:   new_beat.data = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_SIGNED: new_beat.data = sext;
      OP_HIGH:   new_beat.data = {imm, {(DATA_W-IMM_W){1'b0}}};
      OP_BRANCH: new_beat.data = pc4 + (sext << 2);
      OP_JUMP:   new_beat.data = (pc4 & ~JLO_MASK) | DATA_W'({jidx, 2'b00});
      default:   new_beat.err  = 1'b1;
    endcase
  end

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    cnt_d   = cnt_q;
    // A flushed beat is still counted: the counter tracks acceptance, not delivery.
    if (acc && new_beat.err && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q || out_ready) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else begin
        m_d     = acc ? new_beat : m_q;
        m_vld_d = acc;
      end
    end else if (acc) begin
      s_d     = new_beat;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: vector table, handshake corner sequences and random traffic
// checked against a queue-based model of the buffered beats.
module tb_imm_ext_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, err_out;
  logic [2:0]  ext_op;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic [31:0] pc4, imm_out;
  logic [4:0]  tag_in, tag_out;
  logic [7:0]  illegal_cnt;

  logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64, err_out64;
  logic [2:0]  ext_op64;
  logic [11:0] imm64;
  logic [25:0] jidx64;
  logic [63:0] pc4_64, imm_out64;
  logic [4:0]  tag_in64, tag_out64;
  logic [7:0]  illegal_cnt64;

  always #5 clk = ~clk;

  imm_ext_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ext_op(ext_op), .imm(imm), .jidx(jidx), .pc4(pc4), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out), .tag_out(tag_out),
    .err_out(err_out), .illegal_cnt(illegal_cnt));

  imm_ext_pipe #(.DATA_W(64), .IMM_W(12)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
    .ext_op(ext_op64), .imm(imm64), .jidx(jidx64), .pc4(pc4_64), .tag_in(tag_in64),
    .out_valid(out_valid64), .out_ready(out_ready64), .imm_out(imm_out64), .tag_out(tag_out64),
    .err_out(err_out64), .illegal_cnt(illegal_cnt64));

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } mbeat_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] pc4;
    logic [4:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  mbeat_t q[$];
  int     cnt_m;
  int     nvec, nerr;
  bit     acc_last;

  // Extension rules evaluated with plain integer arithmetic on a 32-bit datapath.
  function automatic mbeat_t ref_beat(logic [2:0] op, logic [15:0] im, logic [25:0] ji,
                                      logic [31:0] pc, logic [4:0] tg);
    mbeat_t b;
    longint s;
    b.tag = tg;
    b.err = 1'b0;
    s = (im >= 16'h8000) ? longint'(im) - 65536 : longint'(im);
    case (op)
      3'd0:    b.data = 32'(longint'(im));
      3'd1:    b.data = 32'(s);
      3'd2:    b.data = 32'(longint'(im) * 65536);
      3'd3:    b.data = 32'(longint'(pc) + s * 4);
      3'd4:    b.data = 32'((longint'(pc) / 268435456) * 268435456 + longint'(ji) * 4);
      default: begin b.data = 32'd0; b.err = 1'b1; end
    endcase
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare after the edge.
  task automatic cycle();
    bit     acc, xfer;
    mbeat_t nb;
    acc  = in_valid && (q.size() < 2);
    xfer = (q.size() > 0) && out_ready;
    nb   = ref_beat(ext_op, imm, jidx, pc4, tag_in);
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (acc && nb.err && cnt_m < 255) cnt_m++;
      if (flush) q.delete();
      else begin
        if (xfer) void'(q.pop_front());
        if (acc) q.push_back(nb);
      end
    end
    acc_last = acc && !rst;
    #1;
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("illegal_cnt", 64'(illegal_cnt), 64'(cnt_m));
    if (q.size() > 0) begin
      check("imm_out", 64'(imm_out), 64'(q[0].data));
      check("tag_out", 64'(tag_out), 64'(q[0].tag));
      check("err_out", 64'(err_out), 64'(q[0].err));
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] im, input logic [4:0] tg);
    in_valid = 1'b1;
    ext_op   = op;
    imm      = im;
    tag_in   = tg;
  endtask

  vec_t        tbl[7];
  logic [4:0]  seen[$];
  logic [31:0] held;
  int          k, guard;

  initial begin
    nvec = 0; nerr = 0; cnt_m = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ext_op = 3'd0; imm = 16'd0; jidx = 26'd0; pc4 = 32'h0040_0004; tag_in = 5'd0;
    flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1; ext_op64 = 3'd0;
    imm64 = 12'd0; jidx64 = 26'd0; pc4_64 = 64'd0; tag_in64 = 5'd0;

    cycle(); cycle();
    rst = 1'b0;
    check("rst imm_out", 64'(imm_out), 64'd0);
    check("rst tag_out", 64'(tag_out), 64'd0);
    check("rst err_out", 64'(err_out), 64'd0);

    // Single illegal beat from a clean counter.
    drive(3'b110, 16'h1234, 5'd7);
    cycle();
    in_valid = 1'b0;
    check("illegal imm_out", 64'(imm_out), 64'd0);
    check("illegal err_out", 64'(err_out), 64'd1);
    check("illegal tag_out", 64'(tag_out), 64'd7);
    check("illegal cnt", 64'(illegal_cnt), 64'd1);

    tbl[0] = '{3'b000, 16'h8001, 26'h0, 32'h0040_0004, 5'd1, 32'h0000_8001, 1'b0};
    tbl[1] = '{3'b001, 16'h8001, 26'h0, 32'h0040_0004, 5'd2, 32'hFFFF_8001, 1'b0};
    tbl[2] = '{3'b010, 16'h8001, 26'h0, 32'h0040_0004, 5'd3, 32'h8001_0000, 1'b0};
    tbl[3] = '{3'b011, 16'hFFFF, 26'h0, 32'h0040_0004, 5'd4, 32'h0040_0000, 1'b0};
    tbl[4] = '{3'b100, 16'h0000, 26'h10, 32'h9000_0004, 5'd5, 32'h9000_0040, 1'b0};
    tbl[5] = '{3'b011, 16'h0002, 26'h0, 32'hFFFF_FFFC, 5'd6, 32'h0000_0004, 1'b0};
    tbl[6] = '{3'b111, 16'hFFFF, 26'h3FFFFFF, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].op, tbl[i].imm, tbl[i].tag);
      jidx = tbl[i].jidx;
      pc4  = tbl[i].pc4;
      cycle();
      in_valid = 1'b0;
      check("vec out_valid", 64'(out_valid), 64'd1);
      check("vec imm_out", 64'(imm_out), 64'(tbl[i].exp_data));
      check("vec err_out", 64'(err_out), 64'(tbl[i].exp_err));
      check("vec tag_out", 64'(tag_out), 64'(tbl[i].tag));
    end
    cycle();

    // Back-pressure: two beats fill M and S, in_ready drops, output holds.
    out_ready = 1'b0;
    drive(3'b001, 16'h8001, 5'd1); cycle();
    drive(3'b001, 16'h8002, 5'd2); cycle();
    check("bp in_ready low", 64'(in_ready), 64'd0);
    drive(3'b001, 16'h8003, 5'd3);
    held = imm_out;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp stable imm", 64'(imm_out), 64'(held));
      check("bp stable tag", 64'(tag_out), 64'd1);
    end
    out_ready = 1'b1;
    k = 3; guard = 0;
    while (seen.size() < 4 && guard < 30) begin
      if (k <= 4) drive(3'b001, 16'h8000 + 16'(k), 5'(k));
      else in_valid = 1'b0;
      if (out_valid) seen.push_back(tag_out);
      cycle();
      if (acc_last) k++;
      guard++;
    end
    in_valid = 1'b0;
    check("bp count", 64'(seen.size()), 64'd4);
    for (int i = 0; i < seen.size(); i++) check("bp order", 64'(seen[i]), 64'(i + 1));
    cycle();

    // Flush with M and S full; the blocked input beat must not sneak in.
    out_ready = 1'b0;
    drive(3'b000, 16'h0005, 5'd5); cycle();
    drive(3'b000, 16'h0006, 5'd6); cycle();
    flush = 1'b1;
    drive(3'b000, 16'h0009, 5'd9);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("flush no beat", 64'(out_valid), 64'd0);
    end
    // Illegal beat accepted in the flush cycle is discarded but counted.
    k = cnt_m;
    flush = 1'b1;
    drive(3'b101, 16'h0, 5'd3);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush cnt", 64'(illegal_cnt), 64'(k + 1));
    check("flush drop", 64'(out_valid), 64'd0);

    // Wider instance.
    in_valid64 = 1'b1; ext_op64 = 3'b001; imm64 = 12'h800; tag_in64 = 5'd3;
    cycle();
    ext_op64 = 3'b010;
    check("w64 valid", 64'(out_valid64), 64'd1);
    check("w64 signed", imm_out64, 64'hFFFF_FFFF_FFFF_F800);
    check("w64 tag", 64'(tag_out64), 64'd3);
    cycle();
    in_valid64 = 1'b0;
    check("w64 highpos", imm_out64, 64'h8000_0000_0000_0000);
    check("w64 err", 64'(err_out64), 64'd0);
    check("w64 in_ready", 64'(in_ready64), 64'd1);
    check("w64 cnt", 64'(illegal_cnt64), 64'd0);

    // Reset while M and S are full and flush is asserted.
    out_ready = 1'b0;
    drive(3'b110, 16'h1, 5'd10); cycle();
    drive(3'b110, 16'h2, 5'd11); cycle();
    rst = 1'b1; flush = 1'b1;
    drive(3'b110, 16'h3, 5'd12);
    cycle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("mid rst imm_out", 64'(imm_out), 64'd0);
    check("mid rst tag_out", 64'(tag_out), 64'd0);
    check("mid rst err_out", 64'(err_out), 64'd0);
    check("mid rst cnt", 64'(illegal_cnt), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      ext_op    = 3'($urandom_range(0, 7));
      imm       = 16'($urandom);
      jidx      = 26'($urandom);
      pc4       = $urandom;
      tag_in    = 5'($urandom);
      cycle();
    end
    flush = 1'b0;

    // Counter saturation.
    out_ready = 1'b1;
    drive(3'b111, 16'h0, 5'd1);
    for (int i = 0; i < 300; i++) cycle();
    in_valid = 1'b0;
    cycle();
    check("cnt saturate", 64'(illegal_cnt), 64'd255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Pipelined, parametrised successor to the combinational immediate extender, placed between decode and execute in the pipelined core.
- Extends immediates in five modes: zero, signed, high-position, branch target and jump target.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so a stalled execute stage never drops a beat and decode sees a registered ready.
- Supports flush and counts illegal-mode requests.

Parameters:
- DATA_W, 32, result and PC width.
- IMM_W, 16, immediate field width; legal range 1..DATA_W-2.
- JIDX_W, 26, jump index width; legal range 1..DATA_W-2.
- TAG_W, 5, sideband tag carried unchanged with each beat (e.g. destination register).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- ext_op  in  3  mode: 000 ZERO, 001 SIGNED, 010 HIGHPOS, 011 BRANCH, 100 JUMP, 101-111 illegal.
- imm  in  IMM_W  immediate field.
- jidx  in  JIDX_W  jump index field.
- pc4  in  DATA_W  PC+4 of the instruction.
- tag_in  in  TAG_W  sideband.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- imm_out  out  DATA_W  extended result.
- tag_out  out  TAG_W  sideband of the output beat.
- err_out  out  1  output beat came from an illegal ext_op.
- illegal_cnt  out  8  saturating count of accepted illegal beats.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: out_valid=0, skid empty, in_ready=1, imm_out=0, tag_out=0, err_out=0, illegal_cnt=0. rst overrides flush and all handshakes.
- Result computation (combinational on input, registered on accept); all arithmetic is modulo 2^DATA_W:
  - ZERO: zero-extend imm.
  - SIGNED: sign-extend imm from bit IMM_W-1.
  - HIGHPOS: imm in the top IMM_W bits, zeros below.
  - BRANCH: pc4 + (sign-extended imm << 2). Overflow wraps, no flag.
  - JUMP: {pc4[DATA_W-1:JIDX_W+2], jidx, 2'b00}.
  - Illegal: result 0, err=1.
- Accept and transfer rules:
  - Input is accepted when in_valid && in_ready.
  - Output is transferred when out_valid && out_ready.
  - Latency: an accepted beat appears on the output registers the next cycle when the path is unstalled. Throughput: 1 beat/cycle.
- Storage: main (output) register M and skid register S.
  - in_ready = !S.valid, taken from a register (no combinational path from out_ready).
  - Accept while M empty, or M transferring this cycle: beat goes to M (if S is full, S moves to M instead and the new beat cannot arrive because in_ready=0).
  - Accept while M full and not transferring: beat goes to S; in_ready drops next cycle.
  - M transfers while S full: S moves to M; S empties; in_ready rises next cycle.
- Ordering and stability: beats leave in acceptance order. Output fields stay stable while out_valid && !out_ready.
- Flush (not in reset):
  - M.valid and S.valid clear next cycle; any beat accepted the same cycle is discarded.
  - in_ready=1 the following cycle; illegal_cnt is unaffected by the flush itself.
- illegal_cnt:
  - Increments on each accepted illegal beat, and also counts a beat accepted in the same cycle as flush.
  - Saturates at 255.
  - Cleared only by rst.
- Data registers need not clear when valid drops; only the valid bits and illegal_cnt are reset-critical.
- No X propagation: ext_op values 101-111 are fully defined as illegal.

Test Plan:
- Modes, default params, out_ready=1, pc4=0x00400004:
  - imm=0x8001 with ops 000/001/010 -> 0x00008001 / 0xFFFF8001 / 0x80010000, each one cycle after accept.
  - BRANCH, pc4=0x00400004, imm=0xFFFF -> 0x00400000.
  - JUMP, pc4=0x90000004, jidx=0x0000010 -> 0x90000040.
- Back-pressure: stream 4 SIGNED beats with tags 1..4 and hold out_ready=0 from cycle 1 -> in_ready drops after 2 beats are held. Release out_ready -> tags emerge 1,2,3,4 in order with none lost or duplicated; imm_out stable while stalled.
- Illegal op: ext_op=110, tag=7 -> imm_out=0, err_out=1, tag_out=7, illegal_cnt=1. Send 300 illegal beats -> illegal_cnt=255.
- Flush: M and S full with out_ready=0, assert flush plus a valid input -> out_valid=0 next cycle, in_ready=1, the flushed beats never appear.
- Reset mid-stream: rst=1 while out_valid=1, S full, and flush also asserted -> next cycle all outputs at reset values, including illegal_cnt=0.
- Wrap: BRANCH, pc4=0xFFFFFFFC, imm=0x0002 -> 0x00000004. Parameter sweep DATA_W=64, IMM_W=12 with SIGNED imm=0x800 -> 0xFFFFFFFFFFFFF800.
